unified_mem_bridge: RTL and testbench

- Arbitrates the core's instruction-fetch port and data (LSU) port onto one single-port synchronous SRAM with 1-cycle read latency.
- Sits between the core and the unified program/data memory in the single-core SoC.
- Uses req/gnt/rvalid handshakes on both core ports.
- Routes each response back to its requester.
- Flags out-of-range accesses with an error response instead of touching memory.

---
 rtl/soc_mem_pkg.sv | 17 +
 rtl/mem_arb2.sv | 67 ++++++
 rtl/unified_mem_bridge.sv | 128 ++++++++++++
 tb/tb_unified_mem_bridge.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the unified program/data memory bridge.
package soc_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          WORD_BYTES = 4;

  // Bit positions inside the arbiter's one-hot grant vector
  localparam int GNT_INSTR = 0;
  localparam int GNT_DATA  = 1;

endpackage

// File: rtl/mem_arb2.sv
// Two-requester arbiter (instr fetch vs. LSU) with a one-hot grant.
// Default: data priority with an instr starvation counter bounded by MAX_WAIT.
// UNIFIED_MEM_BRIDGE_RR_EN: plain round-robin on conflicts instead.
module mem_arb2
  import soc_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_req_i,
  input  logic       data_req_i,
  output logic [1:0] gnt_o
);

`ifdef UNIFIED_MEM_BRIDGE_RR_EN
  logic last_data_q;
  logic last_data_d;

  // Conflict goes to whoever did not win last; remember every grant's winner
  always_comb begin
    gnt_o       = '0;
    last_data_d = last_data_q;
    if (!rst_i) begin
      if (instr_req_i && data_req_i) begin
        if (last_data_q) gnt_o[GNT_INSTR] = 1'b1;
        else             gnt_o[GNT_DATA]  = 1'b1;
      end else begin
        gnt_o[GNT_INSTR] = instr_req_i;
        gnt_o[GNT_DATA]  = data_req_i;
      end
    end
    if (gnt_o[GNT_DATA])       last_data_d = 1'b1;
    else if (gnt_o[GNT_INSTR]) last_data_d = 1'b0;
  end

  // Last-winner register; instr after reset so data takes the first conflict
  always_ff @(posedge clk_i) begin
    if (rst_i) last_data_q <= 1'b0;
    else       last_data_q <= last_data_d;
  end
`else
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;
  logic       force_instr;

  // Data wins unless instr has waited MAX_WAIT cycles; count instr denials
  always_comb begin
    force_instr = (wait_cnt_q == 4'(MAX_WAIT));
    gnt_o       = '0;
    if (!rst_i) begin
      if (data_req_i && !(instr_req_i && force_instr)) gnt_o[GNT_DATA]  = 1'b1;
      else if (instr_req_i)                            gnt_o[GNT_INSTR] = 1'b1;
    end
    wait_cnt_d = '0;
    if (instr_req_i && !gnt_o[GNT_INSTR])
      wait_cnt_d = force_instr ? wait_cnt_q : wait_cnt_q + 4'd1;
  end

  // Starvation counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end
`endif

endmodule

// File: rtl/unified_mem_bridge.sv
// Bridges the core's fetch and LSU ports onto one single-port SRAM with
// 1-cycle read latency. Out-of-range accesses are granted but answered
// locally (NOP for fetch, error for LSU) without touching the SRAM.
// Optional build macro: UNIFIED_MEM_BRIDGE_RR_EN (round-robin arbitration).
module unified_mem_bridge
  import soc_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_WAIT    = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           instr_req_i,
  input  logic [31:0]                    instr_addr_i,
  output logic                           instr_gnt_o,
  output logic                           instr_rvalid_o,
  output logic [31:0]                    instr_rdata_o,
  input  logic                           data_req_i,
  input  logic                           data_we_i,
  input  logic [3:0]                     data_be_i,
  input  logic [31:0]                    data_addr_i,
  input  logic [31:0]                    data_wdata_i,
  output logic                           data_gnt_o,
  output logic                           data_rvalid_o,
  output logic [31:0]                    data_rdata_o,
  output logic                           data_err_o,
  output logic                           mem_req_o,
  output logic                           mem_we_o,
  output logic [3:0]                     mem_be_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] mem_addr_o,
  output logic [31:0]                    mem_wdata_o,
  input  logic [31:0]                    mem_rdata_i
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          BYTE_SH   = $clog2(WORD_BYTES);
  localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return (addr - BASE_ADDR) >> BYTE_SH;
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && (word_of(addr) < DEPTH_LIM);
  endfunction

  logic [1:0] gnt;
  logic       instr_in;
  logic       data_in;
  owner_e     owner_q, owner_d;
  logic       err_q, err_d;
  logic       rd_q, rd_d;

  mem_arb2 #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .gnt_o       (gnt)
  );

  assign instr_gnt_o = gnt[GNT_INSTR];
  assign data_gnt_o  = gnt[GNT_DATA];
  assign instr_in    = in_range(instr_addr_i);
  assign data_in     = in_range(data_addr_i);

  // Steer the granted in-range access onto the SRAM and capture response ownership
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    owner_d     = OWN_NONE;
    err_d       = 1'b0;
    rd_d        = 1'b0;
    if (gnt[GNT_INSTR]) begin
      owner_d = OWN_INSTR;
      err_d   = !instr_in;
      rd_d    = 1'b1;
      if (instr_in) begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = AW'(word_of(instr_addr_i));
      end
    end else if (gnt[GNT_DATA]) begin
      owner_d = OWN_DATA;
      err_d   = !data_in;
      rd_d    = !data_we_i;
      if (data_in) begin
        mem_req_o   = 1'b1;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = AW'(word_of(data_addr_i));
        mem_wdata_o = data_wdata_i;
      end
    end
  end

  // ---- grant stage -> response stage ----
  // Single in-flight response: who owns it, whether it errored, whether it returns data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= OWN_NONE;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Route the SRAM read data (or the local substitute) to the owning port
  always_comb begin
    instr_rvalid_o = (owner_q == OWN_INSTR);
    data_rvalid_o  = (owner_q == OWN_DATA);
    data_err_o     = data_rvalid_o && err_q;
    instr_rdata_o  = '0;
    data_rdata_o   = '0;
    if (instr_rvalid_o) instr_rdata_o = err_q ? NOP_INSTR : mem_rdata_i;
    if (data_rvalid_o && !err_q && rd_q) data_rdata_o = mem_rdata_i;
  end

endmodule

// File: tb/tb_unified_mem_bridge.sv
// Self-checking bench for unified_mem_bridge: directed scenarios plus
// randomized traffic against a behavioural reference model and SRAM.
module tb_unified_mem_bridge;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          MAXW  = 4;
  localparam int          AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_i;
  logic          instr_req_i;
  logic [31:0]   instr_addr_i;
  logic          instr_gnt_o, instr_rvalid_o;
  logic [31:0]   instr_rdata_o;
  logic          data_req_i, data_we_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i, data_wdata_i;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]   data_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  unified_mem_bridge #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .MAX_WAIT    (MAXW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  // SRAM with 1-cycle read latency, plus a preload port used during reset
  logic [31:0] sram [DEPTH];
  logic [31:0] sram_q = '0;
  logic        ld_en = 1'b0;
  int          ld_addr = 0;
  logic [31:0] ld_data = '0;
  always @(posedge clk) begin
    if (ld_en) sram[ld_addr] <= ld_data;
    else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else sram_q <= sram[mem_addr_o];
    end
  end
  assign mem_rdata_i = sram_q;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          waits;
  bit          last_was_data;
  bit          p_iv, p_dv, p_de;
  logic [31:0] p_ir, p_dr;
  bit          last_mgi, last_mgd;
  logic        obs_igt;
  logic [31:0] obs_irdata, obs_drdata;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  // Called at a negedge with inputs already driven; checks, then advances one cycle
  task automatic step();
    bit mgi, mgd, ii, di, ereq, ewe;
    logic [3:0]  ebe;
    logic [31:0] eaddr;
    #1;
    mgi = 0; mgd = 0;
`ifdef UNIFIED_MEM_BRIDGE_RR_EN
    if (instr_req_i && data_req_i) begin
      if (last_was_data) mgi = 1; else mgd = 1;
    end else begin
      mgi = instr_req_i; mgd = data_req_i;
    end
`else
    if (data_req_i && !(instr_req_i && waits >= MAXW)) mgd = 1;
    else if (instr_req_i) mgi = 1;
`endif
    ii = addr_ok(instr_addr_i);
    di = addr_ok(data_addr_i);
    ereq = (mgi && ii) || (mgd && di);
    ewe  = mgd && di && data_we_i;
    ebe  = (mgi && ii) ? 4'hF : ((mgd && di) ? data_be_i : 4'h0);
    eaddr = mgi ? 32'(word_idx(instr_addr_i)) : 32'(word_idx(data_addr_i));

    check_eq("instr_gnt", 32'(instr_gnt_o), 32'(mgi));
    check_eq("data_gnt",  32'(data_gnt_o),  32'(mgd));
    check_eq("mem_req",   32'(mem_req_o),   32'(ereq));
    check_eq("mem_we",    32'(mem_we_o),    32'(ewe));
    check_eq("mem_be",    32'(mem_be_o),    32'(ebe));
    if (ereq) check_eq("mem_addr", 32'(mem_addr_o), eaddr);
    if (ewe)  check_eq("mem_wdata", mem_wdata_o, data_wdata_i);
    check_eq("instr_rvalid", 32'(instr_rvalid_o), 32'(p_iv));
    check_eq("instr_rdata",  instr_rdata_o, p_ir);
    check_eq("data_rvalid",  32'(data_rvalid_o), 32'(p_dv));
    check_eq("data_rdata",   data_rdata_o, p_dr);
    check_eq("data_err",     32'(data_err_o), 32'(p_de));
    obs_igt    = instr_gnt_o;
    obs_irdata = instr_rdata_o;
    obs_drdata = data_rdata_o;

    @(posedge clk);
    p_iv = 0; p_ir = '0; p_dv = 0; p_dr = '0; p_de = 0;
    if (mgi) begin
      p_iv = 1;
      p_ir = ii ? ref_mem[word_idx(instr_addr_i)] : 32'h0000_0013;
    end
    if (mgd) begin
      p_dv = 1;
      p_de = !di;
      if (di) begin
        if (data_we_i) begin
          for (int b = 0; b < 4; b++)
            if (data_be_i[b]) ref_mem[word_idx(data_addr_i)][8*b +: 8] = data_wdata_i[8*b +: 8];
        end else p_dr = ref_mem[word_idx(data_addr_i)];
      end
    end
    if (instr_req_i && !mgi) waits = (waits >= MAXW) ? MAXW : waits + 1;
    else                     waits = 0;
    if (mgd) last_was_data = 1;
    else if (mgi) last_was_data = 0;
    last_mgi = mgi;
    last_mgd = mgd;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    instr_req_i = 0; instr_addr_i = '0;
    data_req_i = 0; data_we_i = 0; data_be_i = '0; data_addr_i = '0; data_wdata_i = '0;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1;
    idle_inputs();
    repeat (n) @(negedge clk);
    rst_i = 0;
    waits = 0; last_was_data = 0;
    p_iv = 0; p_ir = '0; p_dv = 0; p_dr = '0; p_de = 0;
    last_mgi = 0; last_mgd = 0;
  endtask

  task automatic set_i(input bit req, input logic [31:0] a);
    instr_req_i = req; instr_addr_i = a;
  endtask

  task automatic set_d(input bit req, input bit we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
    data_req_i = req; data_we_i = we; data_be_i = be; data_addr_i = a; data_wdata_i = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 3));
      1:       return BASE - 32'($urandom_range(1, 8));
      2:       return BASE + 32'(4 * (DEPTH - 1)) + 32'($urandom_range(0, 3));
      3:       return 32'hFFFF_FFFC;
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    rst_i = 1;
    idle_inputs();
    @(negedge clk);
    // Preload SRAM and model while held in reset
    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1; ld_addr = i;
      ld_data = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : $urandom;
      ref_mem[i] = ld_data;
      @(negedge clk);
    end
    ld_en = 0;
    do_reset(2);

    // Reset values with no traffic
    step();

    // Back-to-back fetches of the preloaded words
    set_i(1, BASE + 32'h0); step();
    set_i(1, BASE + 32'h4); step();
    check_eq("fetch0_data", obs_irdata, 32'h11);
    set_i(1, BASE + 32'h8); step();
    check_eq("fetch1_data", obs_irdata, 32'h22);
    idle_inputs(); step();
    check_eq("fetch2_data", obs_irdata, 32'h33);

    // Partial write over a zeroed word, then read back
    set_d(1, 1, 4'hF, BASE + 32'h4, 32'h0);         step();
    set_d(1, 1, 4'b0011, BASE + 32'h4, 32'hDEADBEEF); step();
    set_d(1, 0, 4'hF, BASE + 32'h4, 32'h0);          step();
    idle_inputs(); step();
    check_eq("beef_read", obs_drdata, 32'h0000BEEF);

    // Write with no byte enables leaves the word untouched
    set_d(1, 1, 4'h0, BASE + 32'h8, 32'hA5A5A5A5); step();
    set_d(1, 0, 4'hF, BASE + 32'h8, 32'h0);        step();
    idle_inputs(); step();
    check_eq("be0_read", obs_drdata, 32'h33);

    // Range boundaries
    set_d(1, 0, 4'hF, BASE + 32'(4 * DEPTH), 32'h0);       step();
    set_d(1, 0, 4'hF, BASE + 32'(4 * (DEPTH - 1)), 32'h0); step();
    set_d(1, 1, 4'hF, BASE - 32'h4, 32'h12345678);         step();
    idle_inputs(); set_i(1, BASE + 32'(4 * DEPTH));        step();
    set_i(1, BASE - 32'h4); step();
    check_eq("instr_oor_nop", obs_irdata, 32'h0000_0013);
    idle_inputs(); step();

    // Instr request dropped mid-wait must restart its starvation count
    set_i(1, BASE); set_d(1, 0, 4'hF, BASE + 32'h10, 32'h0); step(); step();
    set_i(0, BASE); step();
    set_i(1, BASE + 32'h14); repeat (6) step();
    idle_inputs(); step();

    // Continuous conflict from a clean reset
    do_reset(2);
    idle_inputs(); step();
    set_i(1, BASE + 32'h20); set_d(1, 0, 4'hF, BASE + 32'h24, 32'h0);
    for (int k = 0; k < 10; k++) begin
      step();
`ifdef UNIFIED_MEM_BRIDGE_RR_EN
      check_eq("arb_pattern", 32'(obs_igt), 32'((k % 2) == 1));
`else
      check_eq("arb_pattern", 32'(obs_igt), 32'((k % (MAXW + 1)) == MAXW));
`endif
    end
    idle_inputs(); step();

    // Reset while a read response is outstanding
    set_d(1, 0, 4'hF, BASE + 32'hC, 32'h0); step();
    do_reset(2);
    step();

    // Randomized traffic respecting the hold-until-grant rule
    for (int n = 0; n < 600; n++) begin
      if (!instr_req_i || last_mgi || $urandom_range(0, 7) == 0)
        set_i($urandom_range(0, 2) != 0, rand_addr());
      if (!data_req_i || last_mgd || $urandom_range(0, 7) == 0)
        set_d($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              rand_addr(), $urandom);
      step();
    end
    idle_inputs(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
